acc_normalizer: RTL and testbench

- Back end of the systolic-array FMA datapath. Takes a signed, un-normalized accumulator mantissa with its exponent, as produced after alignment and accumulation.
- Renormalizes it using a leading-one search, left shift and exponent adjust.
- Rounds and packs the result into a sign/exponent/mantissa float word.
- 3-stage pipeline with a valid/ready handshake on both sides; sits between the PE accumulator output and the result drain.

---
 rtl/acc_normalizer_pkg.sv | 29 ++
 rtl/acc_normalizer_lead_zero_count.sv | 32 +++
 rtl/acc_normalizer.sv | 213 +++++++++++++++++++++
 tb/tb_acc_normalizer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_normalizer_pkg.sv
// ============================================================================
// Module  : acc_normalizer_pkg
// Brief   : Shared types and default widths for the accumulator normalizer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_normalizer_pkg;

    localparam int ACC_WIDTH_DEFAULT  = 32;
    localparam int EXP_WIDTH_DEFAULT  = 8;
    localparam int MANT_WIDTH_DEFAULT = 23;
    localparam int EXP_BIAS           = 127;

    typedef logic        [EXP_WIDTH_DEFAULT-1:0] exponent_t;
    typedef logic signed [ACC_WIDTH_DEFAULT-1:0] accMantNormalSigned_t;

    // Sign bit plus one overflow bit above the biased exponent range
    typedef logic signed [EXP_WIDTH_DEFAULT+1:0] signedExtExp_t;

    typedef struct packed {
        logic                          sign;
        exponent_t                     exp;
        logic [MANT_WIDTH_DEFAULT-1:0] frac;
    } normFloat_t;

endpackage

`default_nettype wire

// File: rtl/acc_normalizer_lead_zero_count.sv
// ============================================================================
// Module  : lead_zero_count
// Brief   : Combinational leading-zero counter; count == WIDTH when all zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lead_zero_count #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]        value,
    output logic [$clog2(WIDTH):0]  count,
    output logic                    allZero
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Scanning upward lets the highest set bit make the final assignment
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign allZero = ~|value;

endmodule

`default_nettype wire

// File: rtl/acc_normalizer.sv
// ============================================================================
// Module  : acc_normalizer
// Brief   : 3-stage normalize/round/pack of a signed accumulator mantissa.
//           Rounding is round-to-nearest-even when NORM_ROUND_RNE_EN is
//           defined, truncation otherwise.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_normalizer
    import acc_normalizer_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEFAULT,
    parameter int EXP_WIDTH  = EXP_WIDTH_DEFAULT,
    parameter int MANT_WIDTH = MANT_WIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ACC_WIDTH-1:0]          in_mant,
    input  logic [EXP_WIDTH-1:0]          in_exp,
    input  logic                          in_isInf,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_WIDTH+MANT_WIDTH:0] out_result,
    output logic                          out_isInf,
    output logic                          out_isZero
);

    localparam int LZ_W      = $clog2(ACC_WIDTH) + 1;
    localparam int XW        = EXP_WIDTH + 2;
    localparam int RES_W     = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int GUARD_BIT = ACC_WIDTH - 2 - MANT_WIDTH;

    // Leading one lands at ACC_WIDTH-1 while the binary point is below ACC_WIDTH-3
    localparam logic signed [XW-1:0] NORM_OFFSET = XW'(2);
    localparam logic signed [XW-1:0] EXP_INF     = XW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO    = '0;

    // ---------------- handshake ----------------
    logic r1_valid, r2_valid, r3_valid;
    logic w_s1_accept, w_s2_accept, w_s3_accept;

    assign w_s3_accept = !r3_valid || out_ready;
    assign w_s2_accept = !r2_valid || w_s3_accept;
    assign w_s1_accept = !r1_valid || w_s2_accept;
    assign in_ready    = w_s1_accept;

    // ---------------- S1: sign/magnitude + LZC ----------------
    logic                 w_sign;
    logic [ACC_WIDTH-1:0] w_mag;
    logic [LZ_W-1:0]      w_lz;
    logic                 w_zero;

    assign w_sign = in_mant[ACC_WIDTH-1];
    assign w_mag  = w_sign ? (-in_mant) : in_mant;

    lead_zero_count #(
        .WIDTH   (ACC_WIDTH)
    ) u_lzc (
        .value   (w_mag),
        .count   (w_lz),
        .allZero (w_zero)
    );

    logic [ACC_WIDTH-1:0] r1_mag;
    logic [LZ_W-1:0]      r1_lz;
    logic                 r1_sign;
    logic [EXP_WIDTH-1:0] r1_exp;
    logic                 r1_inf;
    logic                 r1_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_mag   <= '0;
            r1_lz    <= '0;
            r1_sign  <= 1'b0;
            r1_exp   <= '0;
            r1_inf   <= 1'b0;
            r1_zero  <= 1'b0;
        end else if (w_s1_accept) begin
            r1_valid <= in_valid;
            r1_mag   <= w_mag;
            r1_lz    <= w_lz;
            r1_sign  <= w_sign;
            r1_exp   <= in_exp;
            r1_inf   <= in_isInf;
            r1_zero  <= w_zero;
        end
    end

    // ---------------- S2: shift + exponent adjust ----------------
    logic [ACC_WIDTH-1:0]    w_norm;
    logic signed [XW-1:0]    w_exp_n;
    logic [MANT_WIDTH-1:0]   w_frac;
    logic                    w_unused_norm;

    assign w_norm  = r1_mag << r1_lz;
    assign w_exp_n = $signed({2'b00, r1_exp}) + NORM_OFFSET
                   - $signed({{(XW-LZ_W){1'b0}}, r1_lz});
    assign w_frac  = w_norm[ACC_WIDTH-2 -: MANT_WIDTH];

    logic                  r2_sign;
    logic signed [XW-1:0]  r2_exp_n;
    logic [MANT_WIDTH-1:0] r2_frac;
    logic                  r2_inf;
    logic                  r2_zero;

`ifdef NORM_ROUND_RNE_EN
    logic w_guard, w_sticky;
    logic r2_guard, r2_sticky;

    assign w_guard       = w_norm[GUARD_BIT];
    assign w_sticky      = |w_norm[GUARD_BIT-1:0];
    assign w_unused_norm = w_norm[ACC_WIDTH-1];
`else
    assign w_unused_norm = ^{w_norm[ACC_WIDTH-1], w_norm[GUARD_BIT:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid  <= 1'b0;
            r2_sign   <= 1'b0;
            r2_exp_n  <= '0;
            r2_frac   <= '0;
            r2_inf    <= 1'b0;
            r2_zero   <= 1'b0;
`ifdef NORM_ROUND_RNE_EN
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
`endif
        end else if (w_s2_accept) begin
            r2_valid  <= r1_valid;
            r2_sign   <= r1_sign;
            r2_exp_n  <= w_exp_n;
            r2_frac   <= w_frac;
            r2_inf    <= r1_inf;
            r2_zero   <= r1_zero;
`ifdef NORM_ROUND_RNE_EN
            r2_guard  <= w_guard;
            r2_sticky <= w_sticky;
`endif
        end
    end

    // ---------------- S3: round + classify + pack ----------------
    logic                  w_carry;
    logic [MANT_WIDTH-1:0] w_frac_rnd;
    logic signed [XW-1:0]  w_exp_rnd;

`ifdef NORM_ROUND_RNE_EN
    logic w_round_up;
    assign w_round_up = r2_guard && (r2_sticky || r2_frac[0]);
    assign {w_carry, w_frac_rnd} = {1'b0, r2_frac} + {{MANT_WIDTH{1'b0}}, w_round_up};
`else
    assign w_carry    = 1'b0;
    assign w_frac_rnd = r2_frac;
`endif

    assign w_exp_rnd = r2_exp_n + $signed({{(XW-1){1'b0}}, w_carry});

    logic [RES_W-1:0] w_result;
    logic             w_is_inf;
    logic             w_is_zero;

    always_comb begin
        w_result  = '0;
        w_is_inf  = 1'b0;
        w_is_zero = 1'b0;
        if (r2_inf) begin
            w_result = {r2_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            w_is_inf = 1'b1;
        end else if (r2_zero) begin
            w_is_zero = 1'b1;
        end else if (w_exp_rnd >= EXP_INF) begin
            w_result = {r2_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            w_is_inf = 1'b1;
        end else if (w_exp_rnd <= EXP_ZERO) begin
            w_result  = {r2_sign, {(RES_W-1){1'b0}}};
            w_is_zero = 1'b1;
        end else begin
            w_result = {r2_sign, w_exp_rnd[EXP_WIDTH-1:0], w_frac_rnd};
        end
    end

    logic [RES_W-1:0] r3_result;
    logic             r3_inf;
    logic             r3_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_valid  <= 1'b0;
            r3_result <= '0;
            r3_inf    <= 1'b0;
            r3_zero   <= 1'b0;
        end else if (w_s3_accept) begin
            r3_valid  <= r2_valid;
            r3_result <= w_result;
            r3_inf    <= w_is_inf;
            r3_zero   <= w_is_zero;
        end
    end

    assign out_valid  = r3_valid;
    assign out_result = r3_result;
    assign out_isInf  = r3_inf;
    assign out_isZero = r3_zero;

endmodule

`default_nettype wire

// File: tb/tb_acc_normalizer.sv
// ============================================================================
// Module  : tb_acc_normalizer
// Brief   : Self-checking bench for acc_normalizer against a float model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_normalizer;
    import acc_normalizer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mant;
    logic [7:0]  in_exp;
    logic        in_isInf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_isInf;
    logic        out_isZero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    acc_normalizer #(
        .ACC_WIDTH  (32),
        .EXP_WIDTH  (8),
        .MANT_WIDTH (23)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .in_isInf   (in_isInf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_isInf  (out_isInf),
        .out_isZero (out_isZero)
    );

    // Reference: value = mant * 2^-29 * 2^(exp-127), repacked as binary32
    function automatic logic [33:0] model(input logic [31:0] m, input logic [7:0] e, input logic inf);
        normFloat_t r;
        longint a, q, rem, half;
        int p, be;
        logic sign;
        sign = m[31];
        r = '0;
        if (inf) begin
            r.sign = sign; r.exp = 8'hFF;
            return {2'b10, r};
        end
        a = longint'($signed(m));
        if (a < 0) a = -a;
        if (a == 0) return {2'b01, 32'h0};
        p = 0;
        for (int i = 0; i < 40; i++) if (a >= (longint'(1) << i)) p = i;
        be = int'(e) + p - 29;
        if (p >= 23) begin
            q = a >> (p - 23);
            rem = a - (q << (p - 23));
        end else begin
            q = a << (23 - p);
            rem = 0;
        end
        q = q - (longint'(1) << 23);
        half = 0;
`ifdef NORM_ROUND_RNE_EN
        if (p >= 24) begin
            half = longint'(1) << (p - 24);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
`endif
        if (q == (longint'(1) << 23)) begin q = 0; be = be + 1; end
        r.sign = sign;
        if (be >= 255) begin r.exp = 8'hFF; return {2'b10, r}; end
        if (be <= 0) return {2'b01, r};
        r.exp  = be[7:0];
        r.frac = q[22:0];
        return {2'b00, r};
    endfunction

    task automatic rand_beat(output logic [31:0] m, output logic [7:0] x, output logic f);
        m = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) m = -m;
        if ($urandom_range(0, 19) == 0) m = 32'h0;
        x = 8'($urandom_range(0, 255));
        f = ($urandom_range(0, 15) == 0);
    endtask

    // Drives one beat into an empty pipe and waits (bounded) for its result
    task automatic run_single(input logic [31:0] m, input logic [7:0] x, input logic f,
                              output logic [33:0] got, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_mant = m; in_exp = x; in_isInf = f;
        @(negedge clk);
        in_valid = 1'b0; in_mant = $urandom; in_exp = 8'($urandom); in_isInf = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        got = {out_isInf, out_isZero, out_result};
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_isInf = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_tests++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result got=%h want=0", out_result); end
        n_tests++; if (out_isInf !== 1'b0) begin n_fail++; $display("FAIL reset_out_isInf got=%b want=0", out_isInf); end
        n_tests++; if (out_isZero !== 1'b0) begin n_fail++; $display("FAIL reset_out_isZero got=%b want=0", out_isZero); end
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    localparam logic [31:0] D_MANT [10] = '{32'h2000_0000, 32'hC000_0000, 32'h2000_0020, 32'h2000_0060,
                                             32'h3FFF_FFE0, 32'h0000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                                             32'hFFFF_FFFB, 32'h0000_0000};
    localparam logic [7:0]  D_EXP  [10] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127,
                                             8'd127, 8'd254, 8'd1, 8'd127, 8'd127};
    localparam logic        D_INF  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef NORM_ROUND_RNE_EN
    localparam logic [33:0] D_WANT [10] = '{{2'b00, 32'h3F80_0000}, {2'b00, 32'hC000_0000}, {2'b00, 32'h3F80_0000},
                                             {2'b00, 32'h3F80_0002}, {2'b00, 32'h4000_0000}, {2'b01, 32'h0000_0000},
                                             {2'b10, 32'h7F80_0000}, {2'b01, 32'h8000_0000}, {2'b10, 32'hFF80_0000},
                                             {2'b10, 32'h7F80_0000}};
`else
    localparam logic [33:0] D_WANT [10] = '{{2'b00, 32'h3F80_0000}, {2'b00, 32'hC000_0000}, {2'b00, 32'h3F80_0000},
                                             {2'b00, 32'h3F80_0001}, {2'b00, 32'h3FFF_FFFF}, {2'b01, 32'h0000_0000},
                                             {2'b10, 32'h7F80_0000}, {2'b01, 32'h8000_0000}, {2'b10, 32'hFF80_0000},
                                             {2'b10, 32'h7F80_0000}};
`endif

    task automatic test_directed();
        logic [33:0] got;
        int lat;
        for (int i = 0; i < 10; i++) begin
            run_single(D_MANT[i], D_EXP[i], D_INF[i], got, lat);
            n_tests++;
            if (lat !== 3) begin n_fail++; $display("FAIL directed_latency[%0d] got=%0d want=3", i, lat); end
            n_tests++;
            if (got !== D_WANT[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d] mant=%h got={inf,zero,res}=%b,%b,%h want=%b,%b,%h",
                         i, D_MANT[i], got[33], got[32], got[31:0], D_WANT[i][33], D_WANT[i][32], D_WANT[i][31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp_q[$];
        logic [33:0] e;
        logic [31:0] m;
        logic [7:0]  x;
        logic        f;
        int sent = 0, got = 0, first = -1, last = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
                got++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_output cycle=%0d got=%h want=none", c, out_result);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_isInf, out_isZero, out_result} !== e) begin
                        n_fail++;
                        $display("FAIL b2b_result[%0d] got=%b,%b,%h want=%b,%b,%h",
                                 got - 1, out_isInf, out_isZero, out_result, e[33], e[32], e[31:0]);
                    end
                end
            end
            if (sent < 100) begin
                rand_beat(m, x, f);
                in_valid = 1'b1; in_mant = m; in_exp = x; in_isInf = f;
                #1;
                n_tests++;
                if (in_ready === 1'b1) begin
                    exp_q.push_back(model(m, x, f));
                    sent++;
                end else begin
                    n_fail++; $display("FAIL b2b_in_ready cycle=%0d got=%b want=1", c, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_tests++; if (got !== 100) begin n_fail++; $display("FAIL b2b_count got=%0d want=100", got); end
        n_tests++; if (first !== 3) begin n_fail++; $display("FAIL b2b_first_latency got=%0d want=3", first); end
        n_tests++; if (last - first !== 99) begin n_fail++; $display("FAIL b2b_throughput span got=%0d want=99", last - first); end
    endtask

    task automatic test_backpressure();
        logic [31:0] bm [10];
        logic [7:0]  bx [10];
        logic        bf [10];
        logic [33:0] e, prev_res;
        logic        prev_stall = 1'b0;
        logic        exp_rdy;
        int sent = 0, got = 0;
        for (int i = 0; i < 10; i++) rand_beat(bm[i], bx[i], bf[i]);
        prev_res = '0;
        for (int c = 0; c < 80 && got < 10; c++) begin
            @(negedge clk);
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            in_valid  = (sent < 10);
            if (sent < 10) begin in_mant = bm[sent]; in_exp = bx[sent]; in_isInf = bf[sent]; end
            #1;
            if (prev_stall) begin
                n_tests++;
                if (out_valid !== 1'b1 || {out_isInf, out_isZero, out_result} !== prev_res) begin
                    n_fail++; $display("FAIL bp_hold cycle=%0d got=%b/%h want=1/%h", c, out_valid, out_result, prev_res[31:0]);
                end
            end
            exp_rdy = !((sent - got) == 3 && !out_ready);
            n_tests++;
            if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready cycle=%0d got=%b want=%b", c, in_ready, exp_rdy); end
            if (out_valid && out_ready) begin
                e = model(bm[got], bx[got], bf[got]);
                n_tests++;
                if ({out_isInf, out_isZero, out_result} !== e) begin
                    n_fail++; $display("FAIL bp_result[%0d] got=%b,%b,%h want=%b,%b,%h",
                                       got, out_isInf, out_isZero, out_result, e[33], e[32], e[31:0]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev_res   = {out_isInf, out_isZero, out_result};
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_tests++; if (got !== 10) begin n_fail++; $display("FAIL bp_count got=%0d want=10", got); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] m;
        logic [7:0]  x;
        logic        f;
        logic [33:0] got, e;
        int lat;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_beat(m, x, f);
            in_valid = 1'b1; in_mant = m; in_exp = x; in_isInf = f;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset_valid got=%b want=1", out_valid); end
        rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b want=0", out_valid); end
        n_tests++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL mid_reset_result got=%h want=0", out_result); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
        repeat (3) @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_output got=%b want=0", out_valid); end
        rand_beat(m, x, f);
        e = model(m, x, f);
        run_single(m, x, f, got, lat);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL mid_latency got=%0d want=3", lat); end
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL mid_result got=%h want=%h", got, e); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
